// File: rtl/output_port_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : output_port_transmitter
// Description : Drains two router output FIFOs round-robin, one whole packet
//               per grant, onto the Aurora TX AXI4-Stream interface.
// Revision    : 1.0 - initial release
// ============================================================================
module output_port_transmitter #(
   parameter int AURORA_DATA_WIDTH = 256,
   parameter int NUMBER_PACKET     = 5,
   parameter int CNT_WIDTH         = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         empty_output_port_0,
   output logic                         rd_output_port_0,
   input  logic [AURORA_DATA_WIDTH-1:0] data_output_port_0,
   input  logic                         empty_output_port_1,
   output logic                         rd_output_port_1,
   input  logic [AURORA_DATA_WIDTH-1:0] data_output_port_1,
   input  logic                         tx_channel_up,
   output logic [AURORA_DATA_WIDTH-1:0] m_axi_tx_tdata,
   output logic                         m_axi_tx_tvalid,
   output logic                         m_axi_tx_tlast,
   input  logic                         m_axi_tx_tready,
   output logic                         active_port,
   output logic                         busy,
   output logic [CNT_WIDTH-1:0]         pkt_count_0,
   output logic [CNT_WIDTH-1:0]         pkt_count_1
);

   localparam int                  c_BEAT_W    = $clog2(NUMBER_PACKET);
   localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(NUMBER_PACKET - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_SEND  = 3'd3,
      S_WAIT  = 3'd4
   } state_t;

   state_t                         r_state;
   state_t                         w_next_state;
   logic                           r_active_port;
   logic                           r_rr_ptr;
   logic                           r_busy;
   logic [c_BEAT_W-1:0]            r_beat_cnt;
   logic [AURORA_DATA_WIDTH-1:0]   r_tdata;
   logic                           r_tvalid;
   logic [CNT_WIDTH-1:0]           r_pkt_count_0;
   logic [CNT_WIDTH-1:0]           r_pkt_count_1;

   logic                           w_start;
   logic                           w_start_port;
   logic                           w_locked_empty;
   logic                           w_last_beat;
   logic                           w_handshake;

   assign w_locked_empty = r_active_port ? empty_output_port_1 : empty_output_port_0;
   assign w_last_beat    = (r_beat_cnt == c_LAST_BEAT);
   assign w_handshake    = (r_state == S_SEND) && r_tvalid && m_axi_tx_tready;

   always_comb begin
      w_next_state = r_state;
      w_start      = 1'b0;
      w_start_port = r_rr_ptr;
      case (r_state)
         S_IDLE: begin
            if (tx_channel_up && (!empty_output_port_0 || !empty_output_port_1)) begin
               w_start      = 1'b1;
               // With only one port ready, an empty port 0 means port 1 wins
               w_start_port = (!empty_output_port_0 && !empty_output_port_1) ?
                              r_rr_ptr : empty_output_port_0;
               w_next_state = S_FETCH;
            end
         end
         S_FETCH: w_next_state = S_LOAD;
         S_LOAD:  w_next_state = S_SEND;
         S_SEND: begin
            if (w_handshake) begin
               if (w_last_beat)
                  w_next_state = S_IDLE;
               else if (w_locked_empty)
                  w_next_state = S_WAIT;
               else
                  w_next_state = S_FETCH;
            end
         end
         S_WAIT: begin
            if (!w_locked_empty)
               w_next_state = S_FETCH;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_busy        <= 1'b0;
         r_active_port <= 1'b0;
         r_rr_ptr      <= 1'b0;
         r_beat_cnt    <= '0;
         r_tdata       <= '0;
         r_tvalid      <= 1'b0;
         r_pkt_count_0 <= '0;
         r_pkt_count_1 <= '0;
      end else begin
         r_state <= w_next_state;
         r_busy  <= (w_next_state != S_IDLE);
         if (w_start) begin
            r_active_port <= w_start_port;
            r_beat_cnt    <= '0;
         end
         if (r_state == S_LOAD) begin
            r_tdata  <= r_active_port ? data_output_port_1 : data_output_port_0;
            r_tvalid <= 1'b1;
         end
         if (w_handshake) begin
            r_tvalid <= 1'b0;
            if (w_last_beat) begin
               r_rr_ptr <= ~r_active_port;
               if (r_active_port)
                  r_pkt_count_1 <= r_pkt_count_1 + 1'b1;
               else
                  r_pkt_count_0 <= r_pkt_count_0 + 1'b1;
            end else begin
               r_beat_cnt <= r_beat_cnt + 1'b1;
            end
         end
      end
   end

   assign rd_output_port_0 = (r_state == S_FETCH) && !r_active_port;
   assign rd_output_port_1 = (r_state == S_FETCH) &&  r_active_port;
   assign m_axi_tx_tlast   = (r_state == S_SEND) && w_last_beat;
   assign m_axi_tx_tdata   = r_tdata;
   assign m_axi_tx_tvalid  = r_tvalid;
   assign active_port      = r_active_port;
   assign busy             = r_busy;
   assign pkt_count_0      = r_pkt_count_0;
   assign pkt_count_1      = r_pkt_count_1;

endmodule
`default_nettype wire

// File: tb/tb_output_port_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_port_transmitter
// Description : Directed bench with FIFO models and a stream monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_port_transmitter;

   localparam int DW = 256;
   localparam int NP = 5;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          empty_output_port_0, empty_output_port_1;
   logic          rd_output_port_0, rd_output_port_1;
   logic [DW-1:0] data_output_port_0 = '0;
   logic [DW-1:0] data_output_port_1 = '0;
   logic          tx_channel_up;
   logic [DW-1:0] m_axi_tx_tdata;
   logic          m_axi_tx_tvalid, m_axi_tx_tlast;
   logic          m_axi_tx_tready;
   logic          active_port, busy;
   logic [CW-1:0] pkt_count_0, pkt_count_1;

   output_port_transmitter #(
      .AURORA_DATA_WIDTH(DW), .NUMBER_PACKET(NP), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .empty_output_port_0(empty_output_port_0), .rd_output_port_0(rd_output_port_0),
      .data_output_port_0(data_output_port_0),
      .empty_output_port_1(empty_output_port_1), .rd_output_port_1(rd_output_port_1),
      .data_output_port_1(data_output_port_1),
      .tx_channel_up(tx_channel_up),
      .m_axi_tx_tdata(m_axi_tx_tdata), .m_axi_tx_tvalid(m_axi_tx_tvalid),
      .m_axi_tx_tlast(m_axi_tx_tlast), .m_axi_tx_tready(m_axi_tx_tready),
      .active_port(active_port), .busy(busy),
      .pkt_count_0(pkt_count_0), .pkt_count_1(pkt_count_1)
   );

   always #5 clk = ~clk;

   // FIFO models: bench pushes, DUT pops; read data appears the cycle after rd
   logic [DW-1:0] mem0 [0:127];
   logic [DW-1:0] mem1 [0:127];
   int wr0 = 0, wr1 = 0, rdi0 = 0, rdi1 = 0;
   assign empty_output_port_0 = (wr0 == rdi0);
   assign empty_output_port_1 = (wr1 == rdi1);

   always @(posedge clk) begin
      if (rd_output_port_0) begin
         data_output_port_0 <= mem0[rdi0 % 128];
         rdi0 <= rdi0 + 1;
      end
      if (rd_output_port_1) begin
         data_output_port_1 <= mem1[rdi1 % 128];
         rdi1 <= rdi1 + 1;
      end
   end

   function automatic logic [DW-1:0] mk(input bit port, input int idx);
      logic [DW-1:0] w;
      w            = '0;
      w[255:240]   = 16'hC0DE;
      w[200]       = port;
      w[150:135]   = 16'(idx * 37);
      w[16]        = port;
      w[15:0]      = idx[15:0];
      return w;
   endfunction

   // Stream monitor: logs handshakes and flags protocol violations
   int            rx_n = 0;
   int            mon_err = 0;
   logic [DW-1:0] rx_data [0:255];
   logic          rx_last [0:255];
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;

   always @(posedge clk) begin : mon
      int e;
      e = 0;
      if (!rst_n) begin
         prev_stall <= 1'b0;
      end else begin
         if (m_axi_tx_tvalid && m_axi_tx_tready) begin
            rx_data[rx_n % 256] <= m_axi_tx_tdata;
            rx_last[rx_n % 256] <= m_axi_tx_tlast;
            rx_n <= rx_n + 1;
         end
         if (prev_stall && (!m_axi_tx_tvalid || m_axi_tx_tdata !== prev_data ||
                            m_axi_tx_tlast !== prev_last)) begin
            e = e + 1;
            $display("FAIL stall_hold: tvalid=%b tlast=%b, required held values", m_axi_tx_tvalid, m_axi_tx_tlast);
         end
         if (m_axi_tx_tvalid && !m_axi_tx_tready && (rd_output_port_0 || rd_output_port_1)) begin
            e = e + 1;
            $display("FAIL rd_in_stall: rd0=%b rd1=%b, required 0", rd_output_port_0, rd_output_port_1);
         end
         if ((rd_output_port_0 && empty_output_port_0) || (rd_output_port_1 && empty_output_port_1)) begin
            e = e + 1;
            $display("FAIL rd_empty: read of an empty FIFO");
         end
         prev_stall <= m_axi_tx_tvalid && !m_axi_tx_tready;
         prev_data  <= m_axi_tx_tdata;
         prev_last  <= m_axi_tx_tlast;
      end
      mon_err <= mon_err + e;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [259:0] act, input logic [259:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input bit port, input int n);
      for (int i = 0; i < n; i++) begin
         if (port) begin
            mem1[wr1 % 128] = mk(1'b1, wr1);
            wr1++;
         end else begin
            mem0[wr0 % 128] = mk(1'b0, wr0);
            wr0++;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_pkts(input bit port, input logic [CW-1:0] target, input string nm);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         step();
         done = ((port ? pkt_count_1 : pkt_count_0) == target);
      end
      chk({nm, " timeout"}, 260'(done), 260'(1));
   endtask

   task automatic wait_rx(input int target, input bit need_valid, input string nm);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         step();
         done = (rx_n >= target) && (!need_valid || m_axi_tx_tvalid);
      end
      chk({nm, " timeout"}, 260'(done), 260'(1));
   endtask

   // One packet: NP beats from one port, consecutive FIFO entries, tlast on the final one
   task automatic check_pkt(input int base, input bit port, input int seq, input string nm);
      for (int i = 0; i < NP; i++)
         chk($sformatf("%s beat%0d", nm, i),
             260'({rx_last[(base + i) % 256], rx_data[(base + i) % 256]}),
             260'({(i == NP - 1), mk(port, seq + i)}));
   endtask

   typedef struct {
      logic tready;
      logic rd0, rd1, tvalid, tlast, busy;
      int   beat;
   } vec_t;
   vec_t vec [0:3*NP];

   initial begin
      int s0, s1, base;

      // Single-packet cycle table: per beat FETCH(rd) / LOAD / SEND(tvalid)
      for (int b = 0; b < NP; b++) begin
         vec[3*b]     = '{tready: 1'b1, rd0: 1'b1, rd1: 1'b0, tvalid: 1'b0, tlast: 1'b0, busy: 1'b1, beat: -1};
         vec[3*b + 1] = '{tready: 1'b1, rd0: 1'b0, rd1: 1'b0, tvalid: 1'b0, tlast: 1'b0, busy: 1'b1, beat: -1};
         vec[3*b + 2] = '{tready: 1'b1, rd0: 1'b0, rd1: 1'b0, tvalid: 1'b1, tlast: (b == NP - 1), busy: 1'b1, beat: b};
      end
      vec[3*NP] = '{tready: 1'b1, rd0: 1'b0, rd1: 1'b0, tvalid: 1'b0, tlast: 1'b0, busy: 1'b0, beat: -1};

      rst_n = 1'b0;
      tx_channel_up = 1'b1;
      m_axi_tx_tready = 1'b1;
      step();
      step();
      chk("reset ctrl", 260'({rd_output_port_0, rd_output_port_1, m_axi_tx_tvalid, m_axi_tx_tlast,
                              active_port, busy, pkt_count_0, pkt_count_1}), 260'(0));
      chk("reset tdata", 260'(m_axi_tx_tdata), 260'(0));

      // Single packet from port 0, cycle-exact
      s0 = wr0;
      push(1'b0, NP);
      rst_n = 1'b1;
      for (int k = 0; k <= 3*NP; k++) begin
         m_axi_tx_tready = vec[k].tready;
         step();
         chk($sformatf("t1 cyc%0d rd0,rd1,tv,tl,busy", k),
             260'({rd_output_port_0, rd_output_port_1, m_axi_tx_tvalid, m_axi_tx_tlast, busy}),
             260'({vec[k].rd0, vec[k].rd1, vec[k].tvalid, vec[k].tlast, vec[k].busy}));
         if (vec[k].beat >= 0)
            chk($sformatf("t1 cyc%0d tdata", k), 260'(m_axi_tx_tdata), 260'(mk(1'b0, s0 + vec[k].beat)));
      end
      chk("t1 pkt_count_0", 260'(pkt_count_0), 260'(1));

      // Round-robin over two ports, then counter wrap
      do_reset();
      s0 = wr0; s1 = wr1; base = rx_n;
      push(1'b0, 2*NP);
      push(1'b1, 2*NP);
      wait_pkts(1'b1, 2, "t2 p1x2");
      check_pkt(base,        1'b0, s0,      "t2 pkt0");
      check_pkt(base + NP,   1'b1, s1,      "t2 pkt1");
      check_pkt(base + 2*NP, 1'b0, s0 + NP, "t2 pkt2");
      check_pkt(base + 3*NP, 1'b1, s1 + NP, "t2 pkt3");
      chk("t2 counts", 260'({pkt_count_0, pkt_count_1}), 260'({2'd2, 2'd2}));
      chk("t2 busy drop", 260'(busy), 260'(0));
      push(1'b0, 2*NP);
      push(1'b1, 2*NP);
      wait_pkts(1'b1, 0, "t2 wrap");
      chk("t2 wrap counts", 260'({pkt_count_0, pkt_count_1}), 260'(0));

      // Back-pressure during beat 2
      do_reset();
      s0 = wr0; base = rx_n;
      push(1'b0, NP);
      wait_rx(base + 2, 1'b1, "t3 reach beat2");
      m_axi_tx_tready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("t3 stall%0d", i),
             260'({m_axi_tx_tvalid, m_axi_tx_tlast, rd_output_port_0, rd_output_port_1, m_axi_tx_tdata}),
             260'({4'b1000, mk(1'b0, s0 + 2)}));
      end
      m_axi_tx_tready = 1'b1;
      wait_pkts(1'b0, 1, "t3 done");
      check_pkt(base, 1'b0, s0, "t3 pkt");

      // Locked port starves mid-packet; port 0 must not be serviced
      do_reset();
      s0 = wr0; s1 = wr1; base = rx_n;
      push(1'b1, 2);
      wait_rx(base + 2, 1'b0, "t4 two beats");
      push(1'b0, NP);
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("t4 wait%0d tv,rd0,rd1,busy,port", i),
             260'({m_axi_tx_tvalid, rd_output_port_0, rd_output_port_1, busy, active_port}),
             260'(5'b00011));
      end
      push(1'b1, NP - 2);
      wait_pkts(1'b1, 1, "t4 p1 done");
      check_pkt(base, 1'b1, s1, "t4 pkt1");
      wait_pkts(1'b0, 1, "t4 p0 done");
      check_pkt(base + NP, 1'b0, s0, "t4 pkt0");

      // Channel-up gating
      tx_channel_up = 1'b0;
      do_reset();
      s0 = wr0; s1 = wr1; base = rx_n;
      push(1'b0, NP);
      push(1'b1, NP);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("t5 down%0d rd0,rd1,busy", i),
             260'({rd_output_port_0, rd_output_port_1, busy}), 260'(0));
      end
      tx_channel_up = 1'b1;
      step();
      chk("t5 start rd0,rd1,port", 260'({rd_output_port_0, rd_output_port_1, active_port}), 260'(3'b100));
      wait_rx(base + 1, 1'b0, "t5 beat0");
      tx_channel_up = 1'b0;
      wait_pkts(1'b0, 1, "t5 p0 done");
      check_pkt(base, 1'b0, s0, "t5 pkt0");
      repeat (6) step();
      chk("t5 held busy,cnt1", 260'({busy, pkt_count_1}), 260'(0));
      tx_channel_up = 1'b1;
      wait_pkts(1'b1, 1, "t5 p1 done");
      check_pkt(base + NP, 1'b1, s1, "t5 pkt1");

      // Asynchronous reset during beat 3
      do_reset();
      s0 = wr0; base = rx_n;
      push(1'b0, NP);
      wait_rx(base + 3, 1'b1, "t6 reach beat3");
      rst_n = 1'b0;
      #1;
      chk("t6 reset ctrl", 260'({rd_output_port_0, rd_output_port_1, m_axi_tx_tvalid, m_axi_tx_tlast,
                                 active_port, busy, pkt_count_0, pkt_count_1}), 260'(0));
      chk("t6 reset tdata", 260'(m_axi_tx_tdata), 260'(0));
      push(1'b0, NP - 1);
      step();
      step();
      base = rx_n;
      chk("t6 no partial beat", 260'(base - s0 + s0), 260'(rx_n));
      rst_n = 1'b1;
      wait_pkts(1'b0, 1, "t6 new pkt");
      check_pkt(base, 1'b0, s0 + 4, "t6 pkt");

      chk("monitor violations", 260'(mon_err), 260'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
